mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage placed directly downstream of the execute stage. Consumes the executed instruction word, the ALU result (effective address) and the forwarded rs2 value. Runs RV32I loads and stores over a single-outstanding req/ack data-bus handshake. Stalls upstream while a transfer is in flight and returns a sign- or zero-extended load result to write-back.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles without BusAck before the access is aborted with a fault; range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- instruction  in  32  instruction word held in this stage; Opcode = [6:0], Funct3 = [14:12]
- MemValid  in  1  instruction is valid in this stage
- ALUresult  in  32  effective address from execute
- Reg2RD  in  32  store data (rs2)
- MemStall  out  1  upstream must hold its outputs
- MemDone  out  1  one-cycle pulse: access finished (success or fault)
- MemFault  out  1  qualifies MemDone: misaligned address, unsupported Funct3 or bus timeout
- MemRData  out  32  extended load data; valid while MemDone=1, 0 otherwise
- BusReq  out  1  bus request
- BusWE  out  1  1 = write
- BusAddr  out  32  word address, bits [1:0] = 0
- BusWData  out  32  lane-replicated store data
- BusByteEn  out  4  byte lane enables
- BusAck  in  1  bus completes the transfer this cycle
- BusRData  in  32  read data, valid when BusAck=1

## Operation
- Memory ops: load opcode 7'b0000011 and store opcode 7'b0100011. All other opcodes are pass-through: no stall, no MemDone.
- Supported Funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- Any other Funct3 on a memory op faults. No bus cycle is issued.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on MemValid && memory op, go to WAIT. If the op faults, go to DONE with fault latched instead.
  - WAIT: BusReq=1. On BusAck, capture the data and go to DONE. When the timeout counter reaches TIMEOUT_CYCLES, go to DONE with fault.
  - DONE: MemDone=1 for exactly one cycle, then IDLE.
- MemStall = (IDLE && MemValid && memory op) || WAIT. It is 0 in DONE, so upstream advances on the DONE edge.
- Request fields:
  - BusAddr = {ALUresult[31:2], 2'b00}, registered on IDLE->WAIT.
  - Byte enables: byte = 4'b0001 << a[1:0]; half = 4'b0011 << {a[1],1'b0}; word = 4'b1111.
  - BusWData: SB replicates Reg2RD[7:0] ×4; SH replicates Reg2RD[15:0] ×2; SW uses Reg2RD as is.
- Load data: byte or half selected by the registered address bits, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Stores: MemRData = 0 on completion.
- Fault completion: MemRData = 0, MemFault = 1.

## Timing
- Reset value of every output is 0: MemStall, MemDone, MemFault, MemRData, BusReq, BusWE, BusAddr, BusWData, BusByteEn. State resets to IDLE and the timeout counter to 0.
- Reset acts asynchronously; asserting rst mid-transfer drops BusReq immediately and abandons the access.
- Bus request fields are held stable from the first WAIT cycle through the BusAck cycle inclusive. BusReq deasserts in the cycle after BusAck.
- BusAck outside WAIT is ignored.
- Zero-wait ack (BusAck in the first WAIT cycle): cycle 0 IDLE (stall), cycle 1 WAIT (stall), cycle 2 DONE. Total 2 stall cycles, MemDone at cycle 2.
- Each extra cycle without BusAck adds 1 stall cycle.
- Timeout counter increments each WAIT cycle without ack and clears on leaving WAIT. BusAck in the same cycle the count reaches TIMEOUT_CYCLES: ack wins, no fault.
- Fault detected in IDLE: cycle 0 IDLE (stall), cycle 1 DONE with MemFault=1. BusReq is never asserted.

## Configuration
- MEM_ALIGN_CHECK_EN defined: misaligned accesses fault in IDLE with no bus cycle.
  - halfword: ALUresult[0] != 0
  - word: ALUresult[1:0] != 0
- MEM_ALIGN_CHECK_EN undefined: no alignment check. The low address bits are ignored per size: half uses a[1] only, word uses none. MemFault is then raised only for unsupported Funct3 or timeout.

## Test plan
- LW at 0x0000_1004, BusAck in the first WAIT cycle with BusRData=0xDEAD_BEEF -> BusByteEn=1111, BusAddr=0x1004, MemDone at cycle 2, MemRData=0xDEAD_BEEF, MemStall high for exactly 2 cycles.
- LB at 0x0000_2003 with BusRData=0x80xx_xxxx -> MemRData=0xFFFF_FF80. The same access as LBU -> MemRData=0x0000_0080.
- SH at 0x0000_3002 with Reg2RD=0x1234_ABCD, BusAck after 3 wait cycles -> BusWE=1, BusByteEn=1100, BusWData=0xABCD_ABCD, fields stable until ack, MemRData=0.
- With MEM_ALIGN_CHECK_EN, LW at 0x0000_4001 -> BusReq never asserted, MemDone=1 and MemFault=1 at cycle 1. Without the macro -> bus cycle with BusAddr=0x4000, BusByteEn=1111.
- TIMEOUT_CYCLES=4, BusAck never asserted -> MemDone=1 and MemFault=1 after 4 WAIT cycles, BusReq low in DONE. Repeat with BusAck on the 4th WAIT cycle -> no fault.
- rst asserted during WAIT -> BusReq and MemStall drop to 0 in the same cycle. The next valid op after reset completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-access stage that sits directly after execute. It runs RV32I loads and
// stores over a single-outstanding req/ack data bus. While a transfer is in
// flight it stalls upstream. When the access finishes it pulses MemDone, and
// for loads it returns sign- or zero-extended data.
//
// Optional build macro:
//   MEM_ALIGN_CHECK_EN - when defined, a misaligned halfword or word access
//                        faults without issuing a bus cycle. When undefined,
//                        the low address bits are ignored according to the
//                        access size.
//
// Parameters:
//   TIMEOUT_CYCLES - WAIT cycles without BusAck before the access faults (1..255)
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   instruction           instruction word (opcode [6:0], funct3 [14:12])
//   MemValid              instruction in this stage is valid
//   ALUresult             effective address
//   Reg2RD                store data (rs2)
//   MemStall              upstream must hold
//   MemDone, MemFault     completion pulse and its fault qualifier
//   MemRData              extended load data, non-zero only while MemDone
//   BusReq/WE/Addr/WData/ByteEn   request side of the data bus
//   BusAck, BusRData      completion and read data from the data bus
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access pending; decode and launch (or fault) a memory op
// WAIT   | bus request outstanding; waiting for BusAck or timeout
// DONE   | one-cycle completion pulse towards write-back
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic        MemValid,
   input  logic [31:0] ALUresult,
   input  logic [31:0] Reg2RD,
   output logic        MemStall,
   output logic        MemDone,
   output logic        MemFault,
   output logic [31:0] MemRData,
   output logic        BusReq,
   output logic        BusWE,
   output logic [31:0] BusAddr,
   output logic [31:0] BusWData,
   output logic [3:0]  BusByteEn,
   input  logic        BusAck,
   input  logic [31:0] BusRData
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   // The counter holds the number of ack-less WAIT cycles already completed,
   // so the last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [2:0]  f3_q;
   logic [1:0]  alo_q;
   logic        done_q, fault_q, req_q, we_q;
   logic [31:0] rdata_q, addr_q, wdata_q;
   logic [3:0]  be_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load, is_store, is_mem, f3_ok, misaligned_d, fault_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, ldata_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        unused_instr;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign unused_instr = ^{instruction[31:15], instruction[11:7]};

   always_comb begin
      is_load  = (opcode == OP_LOAD);
      is_store = (opcode == OP_STORE);
      is_mem   = is_load || is_store;

      f3_ok = 1'b0;
      if (is_load) begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
         endcase
      end else if (is_store) begin
         case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
         endcase
      end

      // funct3[1:0] encodes the size for both loads and stores: 00 byte,
      // 01 half, 10 word.
      misaligned_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      case (funct3[1:0])
         2'b01:   misaligned_d = ALUresult[0];
         2'b10:   misaligned_d = |ALUresult[1:0];
         default: misaligned_d = 1'b0;
      endcase
`endif
      fault_d = !f3_ok || misaligned_d;

      case (funct3[1:0])
         2'b00:   be_d = 4'b0001 << ALUresult[1:0];
         2'b01:   be_d = 4'b0011 << {ALUresult[1], 1'b0};
         default: be_d = 4'b1111;
      endcase

      case (funct3[1:0])
         2'b00:   wdata_d = {4{Reg2RD[7:0]}};
         2'b01:   wdata_d = {2{Reg2RD[15:0]}};
         default: wdata_d = Reg2RD;
      endcase

      // Lane selection uses the address bits captured at launch, not the
      // live ALUresult, since upstream may change it once it sees DONE.
      case (alo_q)
         2'b00:   byte_sel = BusRData[7:0];
         2'b01:   byte_sel = BusRData[15:8];
         2'b10:   byte_sel = BusRData[23:16];
         default: byte_sel = BusRData[31:24];
      endcase
      half_sel = alo_q[1] ? BusRData[31:16] : BusRData[15:0];

      case (f3_q)
         3'b000:  ldata_d = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ldata_d = {{16{half_sel[15]}}, half_sel};
         3'b100:  ldata_d = {24'h0, byte_sel};
         3'b101:  ldata_d = {16'h0, half_sel};
         default: ldata_d = BusRData;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         alo_q   <= '0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         rdata_q <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q  <= 1'b0;
               fault_q <= 1'b0;
               rdata_q <= '0;
               cnt_q   <= '0;
               if (MemValid && is_mem) begin
                  if (fault_d) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     fault_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     req_q   <= 1'b1;
                     we_q    <= is_store;
                     addr_q  <= {ALUresult[31:2], 2'b00};
                     wdata_q <= is_store ? wdata_d : 32'h0;
                     be_q    <= be_d;
                     f3_q    <= funct3;
                     alo_q   <= ALUresult[1:0];
                  end
               end
            end
            S_WAIT: begin
               // Ack is checked first so an ack on the final allowed cycle wins.
               if (BusAck) begin
                  state_q <= S_DONE;
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  rdata_q <= we_q ? 32'h0 : ldata_d;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  fault_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               fault_q <= 1'b0;
               rdata_q <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               done_q  <= 1'b0;
               fault_q <= 1'b0;
            end
         endcase
      end
   end

   // Combinational so upstream is held in the very cycle a memory op arrives;
   // gated by rst so the output also reads 0 while reset is asserted.
   assign MemStall  = !rst && (((state_q == S_IDLE) && MemValid && is_mem) ||
                               (state_q == S_WAIT));
   assign MemDone   = done_q;
   assign MemFault  = fault_q;
   assign MemRData  = rdata_q;
   assign BusReq    = req_q;
   assign BusWE     = we_q;
   assign BusAddr   = addr_q;
   assign BusWData  = wdata_q;
   assign BusByteEn = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic        MemValid;
   logic [31:0] ALUresult;
   logic [31:0] Reg2RD;
   logic        MemStall, MemDone, MemFault;
   logic [31:0] MemRData;
   logic        BusReq, BusWE;
   logic [31:0] BusAddr, BusWData;
   logic [3:0]  BusByteEn;
   logic        BusAck;
   logic [31:0] BusRData;

   int total = 0;
   int bad   = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .MemValid(MemValid),
      .ALUresult(ALUresult), .Reg2RD(Reg2RD), .MemStall(MemStall),
      .MemDone(MemDone), .MemFault(MemFault), .MemRData(MemRData),
      .BusReq(BusReq), .BusWE(BusWE), .BusAddr(BusAddr), .BusWData(BusWData),
      .BusByteEn(BusByteEn), .BusAck(BusAck), .BusRData(BusRData)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
      return {17'h0, f3, 5'h0, op};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait access: launch in IDLE, ack in the first WAIT cycle, DONE next.
   task automatic access0(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
      instruction = mk(op, f3);
      ALUresult   = addr;
      Reg2RD      = wd;
      MemValid    = 1'b1;
      #1;
      chk({tag, "_c0_stall"}, MemStall, 1);
      chk({tag, "_c0_req"}, BusReq, 0);
      tick();
      BusAck   = 1'b1;
      BusRData = rd;
      #1;
      chk({tag, "_c1_stall"}, MemStall, 1);
      chk({tag, "_c1_req"}, BusReq, 1);
      chk({tag, "_addr"}, BusAddr, {addr[31:2], 2'b00});
      chk({tag, "_be"}, BusByteEn, exp_be);
      chk({tag, "_we"}, BusWE, (op == OP_STORE));
      if (op == OP_STORE) chk({tag, "_wdata"}, BusWData, exp_wdata);
      tick();
      BusAck   = 1'b0;
      MemValid = 1'b0;
      #1;
      chk({tag, "_done"}, MemDone, 1);
      chk({tag, "_fault"}, MemFault, 0);
      chk({tag, "_rdata"}, MemRData, exp_rdata);
      chk({tag, "_c2_stall"}, MemStall, 0);
      chk({tag, "_c2_req"}, BusReq, 0);
      tick();
      #1;
      chk({tag, "_c3_done"}, MemDone, 0);
      chk({tag, "_c3_rdata"}, MemRData, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; MemValid = 1'b0; instruction = '0; ALUresult = '0;
      Reg2RD = '0; BusAck = 1'b0; BusRData = '0;
      tick(); tick();
      #1;
      chk("rst_stall", MemStall, 0);
      chk("rst_done", MemDone, 0);
      chk("rst_fault", MemFault, 0);
      chk("rst_rdata", MemRData, 0);
      chk("rst_req", BusReq, 0);
      chk("rst_we", BusWE, 0);
      chk("rst_addr", BusAddr, 0);
      chk("rst_wdata", BusWData, 0);
      chk("rst_be", BusByteEn, 0);
      rst = 1'b0;
      tick();

      access0("lw",  OP_LOAD, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      access0("lb",  OP_LOAD, 3'b000, 32'h0000_2003, 32'h0, 32'h8012_3456, 4'b1000, 32'h0, 32'hFFFF_FF80);
      access0("lbu", OP_LOAD, 3'b100, 32'h0000_2003, 32'h0, 32'h8012_3456, 4'b1000, 32'h0, 32'h0000_0080);

      // SH with three ack-less WAIT cycles, ack on the fourth (final allowed) one.
      instruction = mk(OP_STORE, 3'b001);
      ALUresult   = 32'h0000_3002;
      Reg2RD      = 32'h1234_ABCD;
      MemValid    = 1'b1;
      #1;
      chk("sh_c0_stall", MemStall, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) BusAck = 1'b1;
         #1;
         chk("sh_req", BusReq, 1);
         chk("sh_we", BusWE, 1);
         chk("sh_be", BusByteEn, 4'b1100);
         chk("sh_wdata", BusWData, 32'hABCD_ABCD);
         chk("sh_addr", BusAddr, 32'h0000_3000);
         chk("sh_stall", MemStall, 1);
         chk("sh_nodone", MemDone, 0);
      end
      tick();
      BusAck = 1'b0; MemValid = 1'b0;
      #1;
      chk("sh_done", MemDone, 1);
      chk("sh_fault", MemFault, 0);
      chk("sh_rdata", MemRData, 0);
      chk("sh_req_off", BusReq, 0);
      tick();

`ifdef MEM_ALIGN_CHECK_EN
      instruction = mk(OP_LOAD, 3'b010);
      ALUresult   = 32'h0000_4001;
      MemValid    = 1'b1;
      #1;
      chk("mis_c0_stall", MemStall, 1);
      chk("mis_c0_req", BusReq, 0);
      tick();
      #1;
      chk("mis_done", MemDone, 1);
      chk("mis_fault", MemFault, 1);
      chk("mis_req", BusReq, 0);
      chk("mis_rdata", MemRData, 0);
      MemValid = 1'b0;
      tick();
`else
      access0("mis", OP_LOAD, 3'b010, 32'h0000_4001, 32'h0, 32'h1122_3344, 4'b1111, 32'h0, 32'h1122_3344);
`endif

      // Timeout: four WAIT cycles without ack, then a faulting DONE.
      instruction = mk(OP_LOAD, 3'b010);
      ALUresult   = 32'h0000_5000;
      MemValid    = 1'b1;
      BusRData    = 32'h5555_5555;
      #1;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         chk("to_req", BusReq, 1);
         chk("to_stall", MemStall, 1);
         chk("to_nodone", MemDone, 0);
      end
      tick();
      MemValid = 1'b0;
      #1;
      chk("to_done", MemDone, 1);
      chk("to_fault", MemFault, 1);
      chk("to_req_off", BusReq, 0);
      chk("to_rdata", MemRData, 0);
      chk("to_stall_off", MemStall, 0);
      tick();

      // Ack on the fourth WAIT cycle: ack beats the timeout.
      MemValid = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) begin
            BusAck   = 1'b1;
            BusRData = 32'hCAFE_F00D;
         end
         #1;
         chk("ta_req", BusReq, 1);
      end
      tick();
      BusAck = 1'b0; MemValid = 1'b0;
      #1;
      chk("ta_done", MemDone, 1);
      chk("ta_fault", MemFault, 0);
      chk("ta_rdata", MemRData, 32'hCAFE_F00D);
      tick();

      // Unsupported funct3 on a load faults from IDLE with no bus cycle.
      instruction = mk(OP_LOAD, 3'b011);
      ALUresult   = 32'h0000_6000;
      MemValid    = 1'b1;
      #1;
      chk("f3_c0_stall", MemStall, 1);
      tick();
      #1;
      chk("f3_done", MemDone, 1);
      chk("f3_fault", MemFault, 1);
      chk("f3_req", BusReq, 0);
      MemValid = 1'b0;
      tick();

      // Non-memory opcode passes through.
      instruction = mk(OP_ALU, 3'b000);
      MemValid    = 1'b1;
      #1;
      chk("pt_stall", MemStall, 0);
      tick();
      #1;
      chk("pt_done", MemDone, 0);
      chk("pt_req", BusReq, 0);
      MemValid = 1'b0;

      // Stray ack in IDLE is ignored.
      BusAck = 1'b1;
      tick();
      #1;
      chk("stray_done", MemDone, 0);
      chk("stray_req", BusReq, 0);
      BusAck = 1'b0;

      // Reset in WAIT drops request and stall immediately.
      instruction = mk(OP_LOAD, 3'b010);
      ALUresult   = 32'h0000_8000;
      MemValid    = 1'b1;
      tick();
      #1;
      chk("rw_req_on", BusReq, 1);
      rst = 1'b1;
      #1;
      chk("rw_req_off", BusReq, 0);
      chk("rw_stall_off", MemStall, 0);
      chk("rw_addr", BusAddr, 0);
      MemValid = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      access0("lhu", OP_LOAD,  3'b101, 32'h0000_6002, 32'h0, 32'h8765_0000, 4'b1100, 32'h0, 32'h0000_8765);
      access0("lh",  OP_LOAD,  3'b001, 32'h0000_6000, 32'h0, 32'h0000_F00F, 4'b0011, 32'h0, 32'hFFFF_F00F);
      access0("sb",  OP_STORE, 3'b000, 32'h0000_7001, 32'h0000_00AB, 32'hFFFF_FFFF, 4'b0010, 32'hABAB_ABAB, 32'h0);
      access0("sw",  OP_STORE, 3'b010, 32'h0000_7008, 32'h0BAD_F00D, 32'hFFFF_FFFF, 4'b1111, 32'h0BAD_F00D, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
